// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between the pipeline
// writeback (A, always wins) and a buffered long-latency source (B). It also
// tracks registers with outstanding B results and requests bubbles when B starves.
module wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_we,
  input  logic [4:0]  a_waddr,
  input  logic [31:0] a_wdata,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_waddr,
  input  logic [31:0] b_wdata,
  input  logic        iss_we,
  input  logic [4:0]  iss_waddr,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        hazard1,
  output logic        hazard2,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  logic [4:0]    addr_mem [FIFO_DEPTH];
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pending, pending_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic          stall_nxt;
  logic          rf_from_b;
  logic          a_wr, push, pop;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;

  // Handshake and port-selection decisions for this cycle
  assign a_wr      = a_we & (a_waddr != 5'd0);
  assign b_ready   = !rst & (count < CW'(FIFO_DEPTH));
  assign push      = b_valid & b_ready & (b_waddr != 5'd0);
  assign pop       = !a_wr & (count != CW'(0));
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Hazard lookup uses only the registered scoreboard; address 0 never hazards
  assign hazard1 = pending[chk_addr1] & (chk_addr1 != 5'd0);
  assign hazard2 = pending[chk_addr2] & (chk_addr2 != 5'd0);

  // Next scoreboard, starvation counter and stall request
  always_comb begin
    pending_nxt = pending;
    wait_nxt    = wait_cnt;
    stall_nxt   = stall_req;
    // Clear on the B write now on the rf port; a same-cycle issue re-sets it
    if (rf_from_b)
      pending_nxt[rf_waddr] = 1'b0;
    if (iss_we && (iss_waddr != 5'd0))
      pending_nxt[iss_waddr] = 1'b1;
    pending_nxt[0] = 1'b0;
    if (pop || (count == CW'(0)))
      wait_nxt = WW'(0);
    else if (a_wr && (wait_cnt < WW'(MAX_WAIT)))
      wait_nxt = wait_cnt + WW'(1);
    if (pop)
      stall_nxt = 1'b0;
    else if (wait_nxt == WW'(MAX_WAIT))
      stall_nxt = 1'b1;
  end

  // B result storage; contents need no reset since count gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= b_waddr;
      data_mem[wr_ptr] <= b_wdata;
    end
  end

  // Control state, scoreboard and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      pending   <= '0;
      wait_cnt  <= '0;
      stall_req <= 1'b0;
      rf_we     <= 1'b0;
      rf_from_b <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      pending   <= pending_nxt;
      wait_cnt  <= wait_nxt;
      stall_req <= stall_nxt;
      rf_we     <= a_wr | pop;
      rf_from_b <= pop;
      if (a_wr) begin
        rf_waddr <= a_waddr;
        rf_wdata <= a_wdata;
      end else if (pop) begin
        rf_waddr <= head_addr;
        rf_wdata <= head_data;
      end else begin
        rf_waddr <= '0;
        rf_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: A-only, B-only, contention/starvation,
// same-cycle scoreboard set/clear, zero-address discard and mid-run reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_we;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic        iss_we;
  logic [4:0]  iss_waddr;
  logic [4:0]  chk_addr1, chk_addr2;
  logic        hazard1, hazard2;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  wb_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .iss_we(iss_we), .iss_waddr(iss_waddr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hazard1(hazard1), .hazard2(hazard2), .stall_req(stall_req),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; a_we = 1'b0; a_waddr = '0; a_wdata = '0;
    b_valid = 1'b0; b_waddr = '0; b_wdata = '0;
    iss_we = 1'b0; iss_waddr = '0; chk_addr1 = '0; chk_addr2 = '0;

    // Reset state
    tick(); tick();
    chk("rst_rf_we",    32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_stall",    32'(stall_req), 32'd0);
    chk("rst_b_ready",  32'(b_ready), 32'd0);
    rst = 1'b0; #1;
    chk("rel_b_ready",  32'(b_ready), 32'd1);

    // Only A
    a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h11;
    tick();
    chk("a_rf_we",    32'(rf_we), 32'd1);
    chk("a_rf_waddr", 32'(rf_waddr), 32'd3);
    chk("a_rf_wdata", rf_wdata, 32'h11);
    a_waddr = 5'd0; a_wdata = 32'h22;
    tick();
    chk("a0_rf_we", 32'(rf_we), 32'd0);
    a_we = 1'b0;

    // Only B: issue 7 at n
    iss_we = 1'b1; iss_waddr = 5'd7; chk_addr1 = 5'd7; chk_addr2 = 5'd0; #1;
    chk("b_no_bypass", 32'(hazard1), 32'd0);
    tick();                                   // n+1
    iss_we = 1'b0; #1;
    chk("b_haz_set",  32'(hazard1), 32'd1);
    chk("b_haz2_zero", 32'(hazard2), 32'd0);
    tick();                                   // n+2
    tick();                                   // n+3
    b_valid = 1'b1; b_waddr = 5'd7; b_wdata = 32'hABCD;
    tick();                                   // n+4
    b_valid = 1'b0;
    chk("b_n4_rf_we", 32'(rf_we), 32'd0);
    tick();                                   // n+5
    chk("b_rf_we",    32'(rf_we), 32'd1);
    chk("b_rf_waddr", 32'(rf_waddr), 32'd7);
    chk("b_rf_wdata", rf_wdata, 32'hABCD);
    chk("b_haz_n5",   32'(hazard1), 32'd1);
    tick();                                   // n+6
    chk("b_haz_clr",  32'(hazard1), 32'd0);
    chk("b_n6_rf_we", 32'(rf_we), 32'd0);

    // Contention: pending 9 and 10, then A every cycle while B pushes both
    iss_we = 1'b1; iss_waddr = 5'd9;
    tick();
    iss_waddr = 5'd10;
    tick();
    iss_we = 1'b0;
    a_we = 1'b1; a_waddr = 5'd1; a_wdata = 32'hA0;
    b_valid = 1'b1; b_waddr = 5'd9; b_wdata = 32'hB0;       // c0
    tick();
    chk("c1_rf_waddr", 32'(rf_waddr), 32'd1);
    a_waddr = 5'd2; a_wdata = 32'hA1;
    b_waddr = 5'd10; b_wdata = 32'hB1; #1;                   // c1
    chk("c1_b_ready", 32'(b_ready), 32'd1);
    tick();                                                  // c2
    b_valid = 1'b0; a_waddr = 5'd3; #1;
    chk("c2_b_ready_full", 32'(b_ready), 32'd0);
    chk("c2_stall", 32'(stall_req), 32'd0);
    tick();                                                  // c3
    a_waddr = 5'd4;
    tick();                                                  // c4
    a_waddr = 5'd5;
    chk("c4_stall", 32'(stall_req), 32'd0);
    chk("c4_rf_waddr", 32'(rf_waddr), 32'd4);
    tick();                                                  // c5
    chk("c5_stall", 32'(stall_req), 32'd1);
    chk("c5_rf_a", 32'(rf_waddr), 32'd5);
    chk("c5_b_ready_full", 32'(b_ready), 32'd0);
    a_we = 1'b0;
    tick();                                                  // c6: B write of 9
    chk("c6_stall", 32'(stall_req), 32'd0);
    chk("c6_rf_we", 32'(rf_we), 32'd1);
    chk("c6_rf_waddr", 32'(rf_waddr), 32'd9);
    chk("c6_rf_wdata", rf_wdata, 32'hB0);
    chk("c6_b_ready", 32'(b_ready), 32'd1);
    iss_we = 1'b1; iss_waddr = 5'd9;                         // coincides with clear of 9
    chk_addr1 = 5'd9; chk_addr2 = 5'd10;
    tick();                                                  // c7
    iss_we = 1'b0; #1;
    chk("c7_rf_waddr", 32'(rf_waddr), 32'd10);
    chk("c7_rf_wdata", rf_wdata, 32'hB1);
    chk("c7_haz9_kept", 32'(hazard1), 32'd1);
    chk("c7_haz10", 32'(hazard2), 32'd1);
    tick();                                                  // c8
    chk("c8_haz9", 32'(hazard1), 32'd1);
    chk("c8_haz10_clr", 32'(hazard2), 32'd0);
    chk("c8_rf_we", 32'(rf_we), 32'd0);

    // Reset with two buffered entries and pending bits set
    a_we = 1'b1; a_waddr = 5'd2; a_wdata = 32'hD0;
    b_valid = 1'b1; b_waddr = 5'd12; b_wdata = 32'hC0;
    iss_we = 1'b1; iss_waddr = 5'd12;
    tick();
    b_waddr = 5'd13; b_wdata = 32'hC1; iss_waddr = 5'd13;
    tick();
    b_valid = 1'b0; iss_we = 1'b0; chk_addr1 = 5'd12; chk_addr2 = 5'd13; #1;
    chk("r2_b_ready_full", 32'(b_ready), 32'd0);
    chk("r2_haz12", 32'(hazard1), 32'd1);
    rst = 1'b1; a_we = 1'b0; #1;
    chk("r2_b_ready_rst", 32'(b_ready), 32'd0);
    tick();
    chk("r3_rf_we", 32'(rf_we), 32'd0);
    chk("r3_haz12", 32'(hazard1), 32'd0);
    chk("r3_haz13", 32'(hazard2), 32'd0);
    rst = 1'b0; #1;
    chk("r3_b_ready", 32'(b_ready), 32'd1);
    tick();
    chk("r4_rf_we", 32'(rf_we), 32'd0);
    tick();
    chk("r5_rf_we", 32'(rf_we), 32'd0);

    // B result to address 0 is accepted and dropped
    b_valid = 1'b1; b_waddr = 5'd0; b_wdata = 32'hFF;
    tick();
    b_valid = 1'b0; #1;
    chk("z_b_ready", 32'(b_ready), 32'd1);
    tick();
    chk("z_rf_we1", 32'(rf_we), 32'd0);
    tick();
    chk("z_rf_we2", 32'(rf_we), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
